// File: rtl/rx_sample_deframer.sv
// Reassembles 6-byte marker-framed I/Q samples from a show-ahead FIFO into 24-bit I/Q words.
// Latency: a sample appears one clock after its last byte is popped.
// Backpressure: while a sample waits for out_ready, the final byte of the next sample is not popped.
module rx_sample_deframer #(
  parameter int ERR_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [8:0]       fifo_rdata,
  input  logic             fifo_empty,
  output logic             fifo_rdreq,
  input  logic             flush,
  input  logic             sync,
  output logic [23:0]      out_i,
  output logic [23:0]      out_q,
  output logic             out_slot,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [2:0] {HUNT, B1, B2, B3, B4, B5} state_t;

  typedef struct packed {
    logic [23:0] i;
    logic [15:0] q_hi;
  } partial_t;

  state_t   state;
  partial_t part;
  logic     sync_q;
  logic     slot_seq;
  logic     flush_eff;
  logic     hold;
  logic     accept;
  logic     marker;
  logic [7:0] data;

  assign marker    = fifo_rdata[8];
  assign data      = fifo_rdata[7:0];
  // A toggle on sync restarts framing exactly like an explicit flush.
  assign flush_eff = flush | (sync ^ sync_q);
  assign hold      = (state == B5) && out_valid && !out_ready;
  assign fifo_rdreq = !reset && !flush_eff && !fifo_empty && !hold;
  assign accept    = fifo_rdreq;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= HUNT;
      part      <= '0;
      sync_q    <= sync;
      slot_seq  <= 1'b0;
      out_i     <= '0;
      out_q     <= '0;
      out_slot  <= 1'b0;
      out_valid <= 1'b0;
      err_cnt   <= '0;
    end else begin
      sync_q <= sync;
      if (out_valid && out_ready)
        out_valid <= 1'b0;

      if (flush_eff) begin
        state    <= HUNT;
        slot_seq <= 1'b0;
      end else if (accept) begin
        if (marker) begin
          // Marker inside a sample: count the error and resynchronise on this byte.
          if (state != HUNT) begin
            if (err_cnt != {ERR_W{1'b1}})
              err_cnt <= err_cnt + 1'b1;
            slot_seq <= 1'b0;
          end
          part.i[23:16] <= data;
          state         <= B1;
        end else begin
          case (state)
            HUNT: state <= HUNT;
            B1: begin
              part.i[15:8] <= data;
              state        <= B2;
            end
            B2: begin
              part.i[7:0] <= data;
              state       <= B3;
            end
            B3: begin
              part.q_hi[15:8] <= data;
              state           <= B4;
            end
            B4: begin
              part.q_hi[7:0] <= data;
              state          <= B5;
            end
            B5: begin
              out_i     <= part.i;
              out_q     <= {part.q_hi, data};
              out_slot  <= sync & slot_seq;
              slot_seq  <= sync & ~slot_seq;
              out_valid <= 1'b1;
              state     <= HUNT;
            end
            default: state <= HUNT;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_sample_deframer.sv
// Bench for rx_sample_deframer: table vectors, directed corner sequences and a random run against a byte-list model.
module tb_rx_sample_deframer;
  localparam int ERR_W   = 4;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic             clock = 1'b0;
  logic             reset;
  logic [8:0]       fifo_rdata;
  logic             fifo_empty;
  logic             fifo_rdreq;
  logic             flush;
  logic             sync;
  logic [23:0]      out_i;
  logic [23:0]      out_q;
  logic             out_slot;
  logic             out_valid;
  logic             out_ready;
  logic [ERR_W-1:0] err_cnt;

  always #5 clock = ~clock;

  rx_sample_deframer #(.ERR_W(ERR_W)) dut (
    .clock(clock), .reset(reset),
    .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty), .fifo_rdreq(fifo_rdreq),
    .flush(flush), .sync(sync),
    .out_i(out_i), .out_q(out_q), .out_slot(out_slot), .out_valid(out_valid),
    .out_ready(out_ready), .err_cnt(err_cnt)
  );

  typedef struct packed {
    logic [23:0] i;
    logic [23:0] q;
    logic        slot;
  } samp_t;

  int tests = 0;
  int fails = 0;

  logic [8:0] fq[$];
  bit         stall;
  logic [7:0] part[$];
  int         m_err;
  bit         m_slot;
  bit         prev_sync;
  samp_t      exp_q[$];
  samp_t      got[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a sample is simply the marker byte plus the next five unmarked bytes.
  task automatic model_byte(input logic [8:0] w);
    samp_t s;
    if (w[8]) begin
      if (part.size() != 0) begin
        m_err  = (m_err == ERR_MAX) ? ERR_MAX : m_err + 1;
        m_slot = 0;
      end
      part.delete();
      part.push_back(w[7:0]);
    end else if (part.size() != 0) begin
      part.push_back(w[7:0]);
      if (part.size() == 6) begin
        s.i    = {part[0], part[1], part[2]};
        s.q    = {part[3], part[4], part[5]};
        s.slot = sync ? m_slot : 1'b0;
        m_slot = sync ? !m_slot : 1'b0;
        exp_q.push_back(s);
        part.delete();
      end
    end
  endtask

  task automatic step();
    bit    fl, popd, xfer, exp_rd;
    samp_t cap;
    fifo_empty = stall || (fq.size() == 0);
    fifo_rdata = (fq.size() != 0) ? fq[0] : 9'h0;
    #1;
    fl = flush || (sync != prev_sync);
    chk("out_valid", out_valid, exp_q.size() != 0);
    if (out_valid && exp_q.size() != 0) begin
      chk("out_i", out_i, exp_q[0].i);
      chk("out_q", out_q, exp_q[0].q);
      chk("out_slot", out_slot, exp_q[0].slot);
    end
    chk("err_cnt", err_cnt, m_err);
    exp_rd = !fifo_empty && !fl && !(part.size() == 5 && exp_q.size() != 0 && !out_ready);
    chk("fifo_rdreq", fifo_rdreq, exp_rd);
    popd = fifo_rdreq && !fifo_empty;
    xfer = out_valid && out_ready;
    cap  = {out_i, out_q, out_slot};
    @(posedge clock);
    if (xfer) begin
      got.push_back(cap);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    prev_sync = sync;
    if (fl) begin
      part.delete();
      m_slot = 0;
    end else if (popd) begin
      model_byte(fq[0]);
    end
    if (popd) void'(fq.pop_front());
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    flush      = 1'b0;
    fifo_empty = stall || (fq.size() == 0);
    fifo_rdata = (fq.size() != 0) ? fq[0] : 9'h0;
    #1;
    chk("rst_rdreq", fifo_rdreq, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    part.delete();
    exp_q.delete();
    m_err     = 0;
    m_slot    = 0;
    prev_sync = sync;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_i", out_i, 0);
    chk("rst_out_q", out_q, 0);
    chk("rst_out_slot", out_slot, 0);
    chk("rst_err_cnt", err_cnt, 0);
  endtask

  task automatic drain();
    int n = 0;
    stall = 0; out_ready = 1'b1; flush = 1'b0;
    while ((fq.size() != 0 || exp_q.size() != 0) && n < 300) begin
      step();
      n++;
    end
    chk("drain_done", (fq.size() == 0 && exp_q.size() == 0), 1);
    step();
    step();
  endtask

  task automatic push_sample(input logic [23:0] i, input logic [23:0] q);
    fq.push_back({1'b1, i[23:16]});
    fq.push_back({1'b0, i[15:8]});
    fq.push_back({1'b0, i[7:0]});
    fq.push_back({1'b0, q[23:16]});
    fq.push_back({1'b0, q[15:8]});
    fq.push_back({1'b0, q[7:0]});
  endtask

  typedef struct {
    logic [8:0]  pre [3];
    int          npre;
    logic [23:0] i;
    logic [23:0] q;
    logic [23:0] exp_i;
    logic [23:0] exp_q;
    int          exp_err;
  } vec_t;

  vec_t vt [6];

  initial begin
    vt[0] = '{'{9'h000, 9'h000, 9'h000}, 0, 24'hABCDEF, 24'h123456, 24'hABCDEF, 24'h123456, 0};
    vt[1] = '{'{9'h011, 9'h022, 9'h000}, 2, 24'hABCDEF, 24'h123456, 24'hABCDEF, 24'h123456, 0};
    vt[2] = '{'{9'h1AA, 9'h0BB, 9'h0CC}, 3, 24'hABCDEF, 24'h123456, 24'hABCDEF, 24'h123456, 1};
    vt[3] = '{'{9'h1FF, 9'h000, 9'h000}, 1, 24'h010203, 24'h040506, 24'h010203, 24'h040506, 1};
    vt[4] = '{'{9'h000, 9'h000, 9'h000}, 0, 24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000, 0};
    vt[5] = '{'{9'h100, 9'h000, 9'h100}, 3, 24'h800001, 24'h7FFFFE, 24'h800001, 24'h7FFFFE, 2};

    reset = 1'b1; flush = 1'b0; sync = 1'b0; out_ready = 1'b1; stall = 0;
    fifo_empty = 1'b1; fifo_rdata = 9'h0;
    do_reset();

    // Table vectors: each row is preamble bytes plus one good sample.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      got.delete();
      for (int k = 0; k < vt[r].npre; k++) fq.push_back(vt[r].pre[k]);
      push_sample(vt[r].i, vt[r].q);
      drain();
      chk($sformatf("vec%0d_count", r), got.size(), 1);
      if (got.size() > 0) begin
        chk($sformatf("vec%0d_i", r), got[0].i, vt[r].exp_i);
        chk($sformatf("vec%0d_q", r), got[0].q, vt[r].exp_q);
        chk($sformatf("vec%0d_slot", r), got[0].slot, 0);
      end
      chk($sformatf("vec%0d_err", r), err_cnt, vt[r].exp_err);
    end

    // One-clock latency from the sixth pop.
    do_reset();
    push_sample(24'hABCDEF, 24'h123456);
    repeat (5) step();
    chk("lat_before", out_valid, 0);
    step();
    chk("lat_after", out_valid, 1);
    chk("lat_i", out_i, 24'hABCDEF);
    drain();

    // Pair mode slot sequence, then sync toggles restart it.
    sync = 1'b1;
    do_reset();
    got.delete();
    push_sample(24'h111111, 24'h222222);
    push_sample(24'h333333, 24'h444444);
    push_sample(24'h555555, 24'h666666);
    drain();
    chk("pair_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("pair_slot0", got[0].slot, 0);
      chk("pair_slot1", got[1].slot, 1);
      chk("pair_slot2", got[2].slot, 0);
    end
    sync = 1'b0; step();
    sync = 1'b1; step();
    push_sample(24'h777777, 24'h888888);
    drain();
    chk("pair_count4", got.size(), 4);
    if (got.size() == 4) chk("pair_slot3", got[3].slot, 0);
    chk("pair_err", err_cnt, 0);

    // Backpressure: hold the first sample, stall before the last byte of the second.
    sync = 1'b0;
    do_reset();
    got.delete();
    out_ready = 1'b0;
    push_sample(24'hABCDEF, 24'h123456);
    push_sample(24'h654321, 24'hFEDCBA);
    repeat (20) step();
    chk("bp_none_out", got.size(), 0);
    chk("bp_fifo_left", fq.size(), 1);
    chk("bp_held_i", out_i, 24'hABCDEF);
    drain();
    chk("bp_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("bp_first_q", got[0].q, 24'h123456);
      chk("bp_second_i", got[1].i, 24'h654321);
      chk("bp_second_q", got[1].q, 24'hFEDCBA);
    end

    // Reset after three bytes of a sample.
    do_reset();
    got.delete();
    push_sample(24'h0A0B0C, 24'h0D0E0F);
    repeat (3) step();
    do_reset();
    push_sample(24'h123ABC, 24'h456DEF);
    drain();
    chk("rstmid_count", got.size(), 1);
    if (got.size() == 1) chk("rstmid_i", got[0].i, 24'h123ABC);
    chk("rstmid_err", err_cnt, 0);

    // Error counter saturation with stalls.
    do_reset();
    for (int k = 0; k < 20; k++) fq.push_back({1'b1, 8'(k)});
    for (int k = 0; k < 40; k++) begin
      stall = ($urandom_range(0, 3) == 0);
      step();
    end
    drain();
    chk("err_saturate", err_cnt, ERR_MAX);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (fq.size() < 4) begin
        if ($urandom_range(0, 2) == 0)
          push_sample(24'($urandom), 24'($urandom));
        else
          fq.push_back({($urandom_range(0, 5) == 0), 8'($urandom)});
      end
      out_ready = ($urandom_range(0, 3) != 0);
      stall     = ($urandom_range(0, 7) == 0);
      flush     = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 127) == 0) sync = ~sync;
      step();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rx_sample_deframer.md
RX_SAMPLE_DEFRAMER -- requirements
Module: rx_sample_deframer

Interface
REQ-001 Parameter: ERR_W, default 16, width of the saturating framing-error counter.
REQ-002 clock  input  1  system clock; all logic on the rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 fifo_rdata  input  9  show-ahead FIFO head word; bit 8 = start-of-sample marker, bits 7:0 = byte.
REQ-005 fifo_empty  input  1  FIFO empty; fifo_rdata is valid only when low.
REQ-006 fifo_rdreq  output  1  pop request (combinational); a byte is accepted when fifo_rdreq && !fifo_empty.
REQ-007 flush  input  1  discard the partial sample and return to HUNT.
REQ-008 sync  input  1  pair mode: samples alternate primary (slot 0) and secondary (slot 1).
REQ-009 out_i  output  24  I word of the reassembled sample.
REQ-010 out_q  output  24  Q word of the reassembled sample.
REQ-011 out_slot  output  1  0 = primary, 1 = secondary.
REQ-012 out_valid  output  1  output sample valid.
REQ-013 out_ready  input  1  consumer accepts when out_valid && out_ready.
REQ-014 err_cnt  output  ERR_W  saturating count of framing errors.

Function
REQ-015 Wire format: 6 bytes per sample, I[23:16], I[15:8], I[7:0], Q[23:16], Q[15:8], Q[7:0]; only byte 0 carries marker = 1.
REQ-016 States: HUNT, B1, B2, B3, B4, B5; the state advances only when a byte is accepted.
REQ-017 HUNT: accept and discard bytes with marker = 0; on marker = 1, latch I[23:16] and go to B1.
REQ-018 B1..B5: a marker = 0 byte is stored in its field and the state advances; B5 completes the sample and returns to HUNT.
REQ-019 A marker = 1 byte in B1..B5 is a framing error: err_cnt += 1 (saturate at all-ones), the partial sample is discarded, the byte is latched as the new I[23:16], state = B1; out_slot sequencing restarts at 0.
REQ-020 On completion, out_i/out_q/out_slot load and out_valid = 1 in the cycle after the B5 byte is accepted (latency 1 clock from the last byte).
REQ-021 out_valid, out_i, out_q and out_slot hold stable while out_valid && !out_ready.
REQ-022 out_valid clears after a transfer unless a new sample completes in the same cycle, in which case the new sample loads and out_valid stays 1.
REQ-023 fifo_rdreq = !fifo_empty && !(state == B5 && out_valid && !out_ready); in all other cases bytes stream at one per clock.
REQ-024 Slot: with sync = 0, out_slot = 0 always. With sync = 1, out_slot toggles 0,1,0,... per completed sample, starting at 0.
REQ-025 A change in sync (edge detected against a registered copy) acts as flush.
REQ-026 Flush: state = HUNT, partial data discarded, slot sequence = 0, no byte is accepted that cycle (fifo_rdreq = 0). A pending out_valid sample is kept until transferred. err_cnt is unchanged.
REQ-027 Flush has priority over byte acceptance in the same cycle; reset has priority over flush.
REQ-028 fifo_empty high in any state stalls without a state change or error.

Reset
REQ-029 On reset: state = HUNT, out_valid = 0, out_i = 0, out_q = 0, out_slot = 0, err_cnt = 0, slot sequence = 0, and the registered sync copy = current sync (no spurious flush).
REQ-030 Reset mid-sample discards the partial sample; fifo_rdreq = 0 during reset.

Verification
REQ-031 sync = 0, FIFO holds 0x1AB,0x0CD,0x0EF,0x012,0x034,0x056, out_ready = 1 -> one sample out_i = 0xABCDEF, out_q = 0x123456, out_slot = 0, out_valid = 1 one clock after the 6th pop.
REQ-032 Bytes 0x011,0x022 then the valid sample from REQ-031 -> the two bytes are discarded in HUNT, err_cnt = 0, one sample as in REQ-031.
REQ-033 0x1AA,0x0BB,0x0CC, then a full 6-byte sample -> err_cnt = 1, only the second sample is output.
REQ-034 sync = 1, three back-to-back samples -> out_slot sequence 0,1,0; toggling sync before the fourth sample -> next out_slot = 0, err_cnt unchanged.
REQ-035 out_ready = 0 with two samples queued -> the first is held stable, fifo_rdreq drops at B5 of the second, and no byte is lost when out_ready returns to 1.
REQ-036 Assert reset after 3 bytes of a sample, then a full sample -> outputs at reset values, then one correct sample, err_cnt = 0.
